// File: rtl/adc_dual_reader_if.sv
// Host-side handshake between the measurement sequencer and the
// dual-channel ADC readout controller.
//   start       : one-cycle conversion request (sequencer -> controller)
//   busy        : transaction in progress
//   valid       : one-cycle pulse, data_a/data_b new on this cycle
//   data_a/b    : channel results, DATA_BITS wide
//   timeout_err : sticky BUSY-timeout flag, cleared by next accepted start
interface adc_dual_reader_if #(
   parameter int DATA_BITS = 14
);
   logic                 start;
   logic                 busy;
   logic                 valid;
   logic [DATA_BITS-1:0] data_a;
   logic [DATA_BITS-1:0] data_b;
   logic                 timeout_err;

   modport master (
      output start,
      input  busy, valid, data_a, data_b, timeout_err
   );

   modport slave (
      input  start,
      output busy, valid, data_a, data_b, timeout_err
   );
endinterface

// File: rtl/adc_dual_reader.sv
// Conversion/readout controller for a dual simultaneous-sampling serial ADC.
// Issues the CNVST pulse, waits for BUSY high then low (each wait bounded by
// BUSY_TIMEOUT cycles), then clocks both channels in MSB first on SCLK.
// Ports:
//   CLK, RST_N          : system clock, asynchronous active-low reset
//   host (slave)        : start/busy/valid/data_a/data_b/timeout_err
//   CNVST_ADC, CS_ADC   : conversion start / chip select, active low
//   SCLK_ADC            : serial clock, idles high
//   BUSY_ADC            : asynchronous conversion-busy from the ADC
//   DOUTA_ADC/DOUTB_ADC : serial data, sampled on the SCLK rising edge
module adc_dual_reader #(
   parameter int DATA_BITS    = 14,
   parameter int CLK_DIV      = 4,
   parameter int CNV_LOW      = 4,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic                CLK,
   input  logic                RST_N,
   adc_dual_reader_if.slave    host,
   output logic                CNVST_ADC,
   output logic                CS_ADC,
   output logic                SCLK_ADC,
   input  logic                BUSY_ADC,
   input  logic                DOUTA_ADC,
   input  logic                DOUTB_ADC
);

   localparam int M1      = (CLK_DIV > CNV_LOW) ? CLK_DIV : CNV_LOW;
   localparam int CNT_MAX = (M1 > BUSY_TIMEOUT) ? M1 : BUSY_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   // READ is split into 2*DATA_BITS+2 phases of CLK_DIV cycles each:
   // lead-in, DATA_BITS low/high pairs, and the final high hold.
   localparam int NPH     = 2 * DATA_BITS + 2;
   localparam int PW      = $clog2(NPH);

   typedef enum logic [2:0] {IDLE, CONV, WAIT_HI, WAIT_LO, READ, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic [DATA_BITS-1:0] sr_a_q, sr_a_d, sr_b_q, sr_b_d;
   logic [DATA_BITS-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
   logic                 valid_q, valid_d;
   logic                 terr_q, terr_d;
   logic                 cnvst_q, cnvst_d, cs_q, cs_d, sclk_q, sclk_d;
   logic [1:0]           busy_sync;
   logic                 busy_s;

   assign busy_s = busy_sync[1];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         phase_q   <= '0;
         sr_a_q    <= '0;
         sr_b_q    <= '0;
         data_a_q  <= '0;
         data_b_q  <= '0;
         valid_q   <= 1'b0;
         terr_q    <= 1'b0;
         cnvst_q   <= 1'b1;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b1;
         busy_sync <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         sr_a_q    <= sr_a_d;
         sr_b_q    <= sr_b_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         valid_q   <= valid_d;
         terr_q    <= terr_d;
         cnvst_q   <= cnvst_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         busy_sync <= {busy_sync[0], BUSY_ADC};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      sr_a_d   = sr_a_q;
      sr_b_d   = sr_b_q;
      data_a_d = data_a_q;
      data_b_d = data_b_q;
      valid_d  = 1'b0;
      terr_d   = terr_q;
      cnvst_d  = 1'b1;
      cs_d     = 1'b1;
      sclk_d   = 1'b1;
      case (state_q)
         IDLE: begin
            if (host.start) begin
               state_d = CONV;
               cnvst_d = 1'b0;
               cnt_d   = CW'(CNV_LOW - 1);
               terr_d  = 1'b0;
            end
         end
         CONV: begin
            if (cnt_q == '0) begin
               state_d = WAIT_HI;
               cnt_d   = CW'(BUSY_TIMEOUT - 1);
            end else begin
               cnvst_d = 1'b0;
               cnt_d   = cnt_q - CW'(1);
            end
         end
         WAIT_HI: begin
            if (busy_s) begin
               state_d = WAIT_LO;
               cnt_d   = CW'(BUSY_TIMEOUT - 1);
            end else if (cnt_q == '0) begin
               state_d = IDLE;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WAIT_LO: begin
            if (!busy_s) begin
               state_d = READ;
               cs_d    = 1'b0;
               cnt_d   = CW'(CLK_DIV - 1);
               phase_d = '0;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         READ: begin
            cs_d   = 1'b0;
            sclk_d = sclk_q;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (phase_q == PW'(NPH - 1)) begin
               // Results are published on entry to DONE so valid and data
               // line up with the single DONE cycle.
               state_d  = DONE;
               cs_d     = 1'b1;
               data_a_d = sr_a_q;
               data_b_d = sr_b_q;
               valid_d  = 1'b1;
            end else begin
               cnt_d   = CW'(CLK_DIV - 1);
               phase_d = phase_q + PW'(1);
               if (phase_q < PW'(2 * DATA_BITS)) begin
                  if (!phase_q[0]) begin
                     sclk_d = 1'b0;
                  end else begin
                     sclk_d = 1'b1;
                     sr_a_d = {sr_a_q[DATA_BITS-2:0], DOUTA_ADC};
                     sr_b_d = {sr_b_q[DATA_BITS-2:0], DOUTB_ADC};
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign host.busy        = (state_q != IDLE);
   assign host.valid       = valid_q;
   assign host.data_a      = data_a_q;
   assign host.data_b      = data_b_q;
   assign host.timeout_err = terr_q;
   assign CNVST_ADC        = cnvst_q;
   assign CS_ADC           = cs_q;
   assign SCLK_ADC         = sclk_q;

endmodule

// File: tb/tb_adc_dual_reader.sv
`timescale 1ns/1ps
module tb_adc_dual_reader;

   localparam int DB = 14;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic CNVST_ADC, CS_ADC, SCLK_ADC;
   logic busy_pin = 1'b0;
   logic douta = 1'b0, doutb = 1'b0;

   adc_dual_reader_if #(.DATA_BITS(DB)) host_if ();

   adc_dual_reader #(.DATA_BITS(DB), .CLK_DIV(4), .CNV_LOW(4), .BUSY_TIMEOUT(255)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .host      (host_if),
      .CNVST_ADC (CNVST_ADC),
      .CS_ADC    (CS_ADC),
      .SCLK_ADC  (SCLK_ADC),
      .BUSY_ADC  (busy_pin),
      .DOUTA_ADC (douta),
      .DOUTB_ADC (doutb)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_to;
      logic [DB-1:0] a;
      logic [DB-1:0] b;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;

   // reference-model state: last published data
   logic [DB-1:0] mdl_a = '0, mdl_b = '0;

   // ADC model controls
   int adc_mode = 0;          // 0 normal, 1 BUSY tied low, 2 BUSY stuck high
   int busy_ns = 720;
   logic [DB-1:0] pat_a = '0, pat_b = '0;

   int sclk_falls = 0, sclk_rises = 0, sclk_edges = 0, cs_falls = 0;
   int drv_k;
   bit cnv_armed = 0;
   time cnv_t0;
   bit terr_prev = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- ADC behavioural model ----------------
   always @(negedge CNVST_ADC) begin
      cnv_armed = 1;
      cnv_t0 = $time;
      if (adc_mode == 0) begin
         #60 busy_pin = 1'b1;
         #(busy_ns) busy_pin = 1'b0;
      end else if (adc_mode == 2) begin
         #60 busy_pin = 1'b1;
      end
   end

   always @(posedge CNVST_ADC) begin
      if (cnv_armed && RST_N) check("cnvst_low_ns", 32'($time - cnv_t0), 32'd40);
      cnv_armed = 0;
   end

   always @(negedge CS_ADC) begin
      sclk_falls = 0;
      sclk_rises = 0;
      cs_falls++;
   end

   always @(posedge SCLK_ADC) begin
      if (!CS_ADC) begin
         sclk_rises++;
         sclk_edges++;
      end
   end

   always @(negedge SCLK_ADC) begin
      if (!CS_ADC) begin
         drv_k = sclk_falls;
         sclk_falls++;
         sclk_edges++;
         #20;
         if (drv_k < DB) begin
            douta = pat_a[DB-1-drv_k];
            doutb = pat_b[DB-1-drv_k];
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK) begin
      exp_t e;
      if (RST_N && host_if.valid) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_valid: got valid, expected none at %0t", $time);
         end else begin
            e = q.pop_front();
            check("kind_on_valid", 32'(e.is_to), 32'd0);
            check("data_a", 32'(host_if.data_a), 32'(e.a));
            check("data_b", 32'(host_if.data_b), 32'(e.b));
            check("sclk_falls", 32'(sclk_falls), 32'(DB));
            check("sclk_rises", 32'(sclk_rises), 32'(DB));
         end
      end
      if (RST_N && host_if.timeout_err && !terr_prev) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_timeout: got timeout_err, expected none at %0t", $time);
         end else begin
            e = q.pop_front();
            check("kind_on_timeout", 32'(e.is_to), 32'd1);
            check("to_data_a_held", 32'(host_if.data_a), 32'(e.a));
            check("to_data_b_held", 32'(host_if.data_b), 32'(e.b));
            check("to_busy_low", 32'(host_if.busy), 32'd0);
            check("to_cs_never_fell", 32'(cs_falls), 32'd0);
         end
      end
      terr_prev = host_if.timeout_err;
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      while (host_if.busy !== 1'b0 && n < 4000) begin
         @(negedge CLK);
         n++;
      end
      check("dut_idle", 32'(host_if.busy), 32'd0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (q.size() != 0 && n < 4000) begin
         @(negedge CLK);
         n++;
      end
      check("txn_complete", 32'(q.size()), 32'd0);
      q.delete();
      repeat (3) @(negedge CLK);
   endtask

   task automatic issue(input int mode, input logic [DB-1:0] pa, input logic [DB-1:0] pb, input int bns);
      exp_t e;
      wait_idle();
      adc_mode = mode;
      busy_ns = bns;
      pat_a = pa;
      pat_b = pb;
      e.is_to = (mode != 0);
      if (mode == 0) begin
         mdl_a = pa;
         mdl_b = pb;
      end
      e.a = mdl_a;
      e.b = mdl_b;
      q.push_back(e);
      cs_falls = 0;
      sclk_edges = 0;
      @(negedge CLK) host_if.start = 1'b1;
      @(negedge CLK) host_if.start = 1'b0;
      check("accept_busy", 32'(host_if.busy), 32'd1);
      check("accept_terr_clr", 32'(host_if.timeout_err), 32'd0);
   endtask

   task automatic wait_cs_low();
      int n = 0;
      while (CS_ADC !== 1'b0 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      check("cs_fell", 32'(CS_ADC), 32'd0);
   endtask

   initial begin
      exp_t e;
      int n;
      host_if.start = 1'b0;
      #23;
      check("rst_cnvst", 32'(CNVST_ADC), 32'd1);
      check("rst_cs", 32'(CS_ADC), 32'd1);
      check("rst_sclk", 32'(SCLK_ADC), 32'd1);
      check("rst_busy", 32'(host_if.busy), 32'd0);
      check("rst_valid", 32'(host_if.valid), 32'd0);
      check("rst_data_a", 32'(host_if.data_a), 32'd0);
      check("rst_terr", 32'(host_if.timeout_err), 32'd0);
      @(negedge CLK) RST_N = 1'b1;
      repeat (3) @(negedge CLK);

      // nominal transaction
      issue(0, 14'h2A5C, 14'h15A3, 720);
      wait_done();

      // BUSY tied low -> WAIT_HI timeout, then recovery
      issue(1, 14'h0, 14'h0, 0);
      wait_done();
      check("terr_sticky", 32'(host_if.timeout_err), 32'd1);
      issue(0, 14'h1234, 14'h0ABC, 720);
      wait_done();

      // BUSY stuck high -> WAIT_LO timeout
      issue(2, 14'h0, 14'h0, 0);
      wait_done();
      busy_pin = 1'b0;
      adc_mode = 0;
      repeat (5) @(negedge CLK);

      // extra starts during READ are ignored; start right after valid is accepted
      issue(0, 14'h0F0F, 14'h30C3, 500);
      wait_cs_low();
      repeat (3) begin
         @(negedge CLK) host_if.start = 1'b1;
         @(negedge CLK) host_if.start = 1'b0;
         repeat (5) @(negedge CLK);
      end
      n = 0;
      while (host_if.valid !== 1'b1 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      check("valid_seen", 32'(host_if.valid), 32'd1);
      pat_a = 14'h2222;
      pat_b = 14'h1DDD;
      busy_ns = 400;
      mdl_a = pat_a;
      mdl_b = pat_b;
      e.is_to = 0; e.a = mdl_a; e.b = mdl_b;
      @(negedge CLK);
      q.push_back(e);
      cs_falls = 0;
      host_if.start = 1'b1;
      @(negedge CLK) host_if.start = 1'b0;
      check("b2b_accept", 32'(host_if.busy), 32'd1);
      wait_done();

      // reset mid-read
      issue(0, 14'h1555, 14'h2AAA, 720);
      n = 0;
      while (sclk_edges < 7 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      check("seven_edges", 32'(sclk_edges >= 7), 32'd1);
      RST_N = 1'b0;
      #1;
      q.delete();
      mdl_a = '0;
      mdl_b = '0;
      check("mid_rst_cs", 32'(CS_ADC), 32'd1);
      check("mid_rst_sclk", 32'(SCLK_ADC), 32'd1);
      check("mid_rst_cnvst", 32'(CNVST_ADC), 32'd1);
      check("mid_rst_valid", 32'(host_if.valid), 32'd0);
      check("mid_rst_data_a", 32'(host_if.data_a), 32'd0);
      check("mid_rst_data_b", 32'(host_if.data_b), 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      issue(0, 14'h2A5C, 14'h15A3, 720);
      wait_done();

      // edge patterns
      issue(0, 14'h3FFF, 14'h0000, 720);
      wait_done();
      issue(0, 14'h0001, 14'h2000, 720);
      wait_done();

      // randomized traffic
      for (int i = 0; i < 10; i++) begin
         if (($urandom % 5) == 0) begin
            issue(1, 14'h0, 14'h0, 0);
         end else begin
            issue(0, DB'($urandom_range(0, 16383)), DB'($urandom_range(0, 16383)),
                  int'($urandom_range(150, 1500)));
         end
         wait_done();
         repeat ($urandom_range(0, 5)) @(negedge CLK);
      end

      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got no finish, expected finish before %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/adc_dual_reader.md
Name: adc_dual_reader

Overview:
- Conversion/readout controller for the on-board dual simultaneous-sampling 14-bit serial ADC (CNVST/BUSY/CS/SCLK, DOUTA/DOUTB).
- Sits between the measurement sequencer, which issues `start`, and the result pipe-out FIFO, which consumes `data_a`/`data_b` on `valid`.
- Owns all ADC pin timing: conversion pulse, BUSY handshake with timeout, and MSB-first serial shift-in of both channels at once.

Parameters:
- DATA_BITS, 14: bits per channel per conversion.
- CLK_DIV, 4: CLK cycles per SCLK half-period; must be ≥2. At 100 MHz CLK this gives 12.5 MHz SCLK.
- CNV_LOW, 4: CLK cycles CNVST_ADC is held low.
- BUSY_TIMEOUT, 255: maximum CLK cycles spent waiting on each BUSY edge.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to convert and read one sample pair.
- busy  out  1  high while a transaction is in progress (any state other than IDLE).
- valid  out  1  one-cycle pulse; data_a/data_b are new on this cycle.
- data_a  out  DATA_BITS  channel A result, MSB first on wire.
- data_b  out  DATA_BITS  channel B result.
- timeout_err  out  1  sticky; set on BUSY timeout; cleared by the next accepted start.
- CNVST_ADC  out  1  conversion start, active low.
- CS_ADC  out  1  chip select, active low.
- SCLK_ADC  out  1  serial clock, idles high.
- BUSY_ADC  in  1  ADC conversion in progress, asynchronous.
- DOUTA_ADC  in  1  channel A serial data.
- DOUTB_ADC  in  1  channel B serial data.

Behaviour:
- Reset values, applied asynchronously on RST_N low:
  - CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1.
  - busy=0, valid=0, data_a=0, data_b=0, timeout_err=0.
  - State=IDLE, all counters 0.
- Reset mid-transaction aborts immediately; no valid is issued for the aborted transaction.
- BUSY_ADC passes through a 2-flop synchronizer; all BUSY decisions use the synchronized value.
- DOUTx are sampled directly, not synchronized. ADC data settles ≤20 ns after the SCLK falling edge.
- State machine:
  - IDLE:
    - start=1 → CONV.
    - Entering CONV clears timeout_err and loads the cycle counter.
    - start in any other state is ignored (no queueing).
  - CONV:
    - CNVST_ADC=0 for exactly CNV_LOW cycles, then CNVST_ADC=1 → WAIT_HI.
  - WAIT_HI:
    - Synchronized BUSY=1 → WAIT_LO.
    - BUSY_TIMEOUT cycles without BUSY → set timeout_err, go to IDLE, no valid.
  - WAIT_LO:
    - Synchronized BUSY=0 → READ.
    - Timeout counter restarts on entry to WAIT_LO; on expiry, same action as in WAIT_HI.
  - READ:
    - CS_ADC=0 for the whole state.
    - First SCLK falling edge occurs CLK_DIV cycles after CS_ADC falls.
    - SCLK_ADC toggles every CLK_DIV cycles, for DATA_BITS full low/high periods.
    - On the CLK edge that drives SCLK_ADC high, DOUTA_ADC/DOUTB_ADC shift into the LSB of their shift registers, so the first bit received ends as the MSB.
    - After the DATA_BITS-th rising edge, hold SCLK_ADC high for CLK_DIV cycles, then CS_ADC=1 → DONE.
  - DONE (1 cycle):
    - Copy the shift registers to data_a/data_b and pulse valid=1 → IDLE.
    - start asserted in the DONE cycle is ignored; busy=0 resumes on the next cycle.
- data_a/data_b hold their last value until the next valid; timeouts do not modify them.
- Per-transaction SCLK count is exactly DATA_BITS falling and DATA_BITS rising edges; no extra edges.
- Latency from start to valid: 1 + CNV_LOW + (BUSY high wait) + (BUSY low wait) + 2 (sync) + (2·DATA_BITS+2)·CLK_DIV + 1 cycles.
- Back-to-back operation: start may be asserted on the cycle after valid and is accepted.

Test Plan:
- ADC model: BUSY rises 60 ns after CNVST falls and stays high 720 ns. DOUTA drives 0x2A5C and DOUTB drives 0x15A3, MSB first, each bit changing 20 ns after SCLK falls. One start → valid pulses once with data_a=0x2A5C and data_b=0x15A3. Check 14 SCLK falls while CS_ADC=0 and CNVST_ADC low for exactly 40 ns.
- BUSY tied low; start → timeout_err=1 after 255 cycles in WAIT_HI; busy returns to 0; no valid; data_a/data_b unchanged. A following normal start clears timeout_err and completes.
- BUSY stuck high after the conversion start → timeout_err raised after 255 cycles in WAIT_LO; CS_ADC never falls.
- start pulsed repeatedly during READ → exactly one valid; the second transaction begins only from a start issued after valid.
- RST_N asserted after the 7th SCLK edge → CS_ADC, SCLK_ADC and CNVST_ADC are 1 immediately; valid=0; data outputs read 0. A post-reset start completes with correct data.
- Channel patterns 0x3FFF / 0x0000, then 0x0001 / 0x2000 → both channels captured exactly, with no bit slip or cross-channel mixing.
